memory_access_controller: RTL and testbench
===========================================

MEMORY_ACCESS_CONTROLLER -- requirements
Module: memory_access_controller

Interface
REQ-001 Parameter RAM_LAT, default 1, meaning RAM read latency in cycles from address presented to ram_rdata valid; legal range 1..4.
REQ-002 clk  input  1  single clock; all state SHALL update on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 fetch_req  input  1  instruction fetch request, level, held until instr_valid.
REQ-005 pc_instr_access  input  8  PC fetch address.
REQ-006 data_req  input  1  LDR/STR request, level, held until data_valid.
REQ-007 data_we  input  1  1=STR, 0=LDR.
REQ-008 data_addr  input  16  register-bank load/store address.
REQ-009 data_wdata  input  32  STR write data.
REQ-010 ram_rdata  input  32  RAM read data.
REQ-011 sel_add_bus  output  1  address-bus select; 1=data address, 0=PC.
REQ-012 address_add_bus_out  output  16  RAM address.
REQ-013 ram_we  output  1  RAM write strobe.
REQ-014 ram_wdata  output  32  RAM write data.
REQ-015 instr_out  output  32  fetched instruction.
REQ-016 instr_valid  output  1  one-cycle fetch completion pulse.
REQ-017 data_rdata  output  32  LDR read data.
REQ-018 data_valid  output  1  one-cycle LDR/STR completion pulse.
REQ-019 busy  output  1  high in every state except IDLE.

Function
REQ-020 FSM states SHALL be IDLE, ACCESS, WAIT, RESP.
REQ-021 IDLE: on any request, grant one requester, register its address/we/wdata, go to ACCESS next cycle; no request stays IDLE.
REQ-022 Arbitration: data_req wins, except when last grant was data and fetch_req is pending, then fetch wins; only one grant per IDLE cycle.
REQ-023 ACCESS lasts exactly 1 cycle; ram_we=1 only in ACCESS of an STR grant.
REQ-024 WAIT lasts RAM_LAT-1 cycles via down-counter; skipped when RAM_LAT=1.
REQ-025 On last ACCESS/WAIT cycle, ram_rdata SHALL be registered into instr_out (fetch) or data_rdata (LDR); STR leaves data_rdata unchanged.
REQ-026 RESP lasts 1 cycle, asserts instr_valid or data_valid (never both), then returns to IDLE.
REQ-027 Latency: request sampled in IDLE at cycle t -> valid pulse at cycle t+1+RAM_LAT.
REQ-028 sel_add_bus=1 and address_add_bus_out=registered data_addr during ACCESS/WAIT of data grants; otherwise sel_add_bus=0 and address_add_bus_out={8'h00, PC}, zero-extended.
REQ-029 PC used for a fetch is the value registered at grant; changes to inputs during ACCESS/WAIT/RESP SHALL be ignored.
REQ-030 Request deasserted mid-transaction: transaction completes and valid pulse still issues.
REQ-031 Request held through RESP: re-arbitrated in next IDLE, producing a new transaction (minimum 2+RAM_LAT cycles per transaction).
REQ-032 ram_wdata SHALL equal registered data_wdata during STR ACCESS, else 0.

Reset
REQ-033 On reset: state IDLE, last-grant=fetch, counter 0; all outputs 0 (address_add_bus_out={8'h00,pc_instr_access}, combinational through the mux).
REQ-034 Reset mid-transaction SHALL abort immediately: no valid pulse, ram_we=0, no capture.

Structure
REQ-035 Shared package mem_ctrl_pkg SHALL hold state encodings, grant encoding (GRANT_FETCH, GRANT_DATA), ADDR_W=16, PC_W=8, DATA_W=32, RAM_LAT bounds.
REQ-036 One sub-module, addr_bus_mux, SHALL implement the sel_add_bus PC/data address selection; FSM, arbiter, counter and capture registers live in the top.

Verification
REQ-037 RAM_LAT=1, fetch_req with PC=8'h2A -> address 16'h002A, sel=0, instr_valid at t+2 with instr_out=ram_rdata sampled at t+1.
REQ-038 RAM_LAT=3, LDR addr 16'h1234 -> sel=1 for 3 cycles, data_valid at t+4, data_rdata=RAM word.
REQ-039 STR addr 16'h00F0, wdata 32'hDEADBEEF -> ram_we exactly one cycle with matching address/data, data_valid at t+1+RAM_LAT, data_rdata unchanged.
REQ-040 fetch_req and data_req both held -> grants alternate data, fetch, data, fetch; no starvation.
REQ-041 reset asserted in WAIT (RAM_LAT=3) -> same-cycle IDLE, all outputs 0, no valid pulse; post-reset fetch proceeds normally.
REQ-042 PC changed 8'h10->8'h11 during ACCESS -> address stays 16'h0010 until RESP.

Source files
------------

// File: rtl/memory_access_controller_pkg.sv
// Shared types and widths for the memory access controller and its address mux.
package mem_ctrl_pkg;

    localparam int ADDR_W      = 16;
    localparam int PC_W        = 8;
    localparam int DATA_W      = 32;
    localparam int RAM_LAT_MIN = 1;
    localparam int RAM_LAT_MAX = 4;
    localparam int CNT_W       = 3;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_WAIT   = 2'd2,
        ST_RESP   = 2'd3
    } state_t;

    typedef enum logic {
        GRANT_FETCH = 1'b0,
        GRANT_DATA  = 1'b1
    } grant_t;

endpackage

// File: rtl/memory_access_controller_addr_bus_mux.sv
// RAM address-bus source select: registered data address or zero-extended PC.
module addr_bus_mux
    import mem_ctrl_pkg::*;
(
    input  logic              sel_add_bus,
    input  logic [PC_W-1:0]   pc,
    input  logic [ADDR_W-1:0] data_addr,
    output logic [ADDR_W-1:0] address_add_bus_out
);

    assign address_add_bus_out = sel_add_bus ? data_addr
                                             : {{(ADDR_W-PC_W){1'b0}}, pc};

endmodule

// File: rtl/memory_access_controller.sv
// Arbitrates instruction fetches and LDR/STR accesses onto a single RAM port.
//
// state  | meaning
// IDLE   | no transaction; arbitrate and register the granted request
// ACCESS | address on the bus for one cycle; write strobe for STR
// WAIT   | RAM_LAT-1 further cycles of read latency (down-counter)
// RESP   | one-cycle completion pulse, then back to IDLE
module memory_access_controller
    import mem_ctrl_pkg::*;
#(
    parameter int RAM_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              fetch_req,
    input  logic [PC_W-1:0]   pc_instr_access,
    input  logic              data_req,
    input  logic              data_we,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [DATA_W-1:0] data_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic              sel_add_bus,
    output logic [ADDR_W-1:0] address_add_bus_out,
    output logic              ram_we,
    output logic [DATA_W-1:0] ram_wdata,
    output logic [DATA_W-1:0] instr_out,
    output logic              instr_valid,
    output logic [DATA_W-1:0] data_rdata,
    output logic              data_valid,
    output logic              busy
);

    state_t             state;
    grant_t             grant;
    grant_t             last_grant;
    logic [CNT_W-1:0]   cnt;
    logic [PC_W-1:0]    pc_q;
    logic [ADDR_W-1:0]  daddr_q;
    logic               we_q;
    logic               xfer;
    logic               grant_data;
    logic               any_req;
    logic               last_beat;
    logic [PC_W-1:0]    pc_bus;

    // Data normally wins; a fetch waiting behind a data grant gets the next turn.
    assign grant_data = data_req && !(last_grant == GRANT_DATA && fetch_req);
    assign any_req    = data_req || fetch_req;
    assign last_beat  = (state == ST_ACCESS && cnt == '0) ||
                        (state == ST_WAIT   && cnt == CNT_W'(1));

    // The PC captured at grant drives the bus for the whole transfer.
    assign pc_bus = xfer ? pc_q : pc_instr_access;

    addr_bus_mux u_addr_bus_mux (
        .sel_add_bus         (sel_add_bus),
        .pc                  (pc_bus),
        .data_addr           (daddr_q),
        .address_add_bus_out (address_add_bus_out)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= ST_IDLE;
            grant       <= GRANT_FETCH;
            last_grant  <= GRANT_FETCH;
            cnt         <= '0;
            pc_q        <= '0;
            daddr_q     <= '0;
            we_q        <= 1'b0;
            xfer        <= 1'b0;
            sel_add_bus <= 1'b0;
            ram_we      <= 1'b0;
            ram_wdata   <= '0;
            instr_out   <= '0;
            instr_valid <= 1'b0;
            data_rdata  <= '0;
            data_valid  <= 1'b0;
            busy        <= 1'b0;
        end else begin
            instr_valid <= 1'b0;
            data_valid  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (any_req) begin
                        grant       <= grant_data ? GRANT_DATA : GRANT_FETCH;
                        last_grant  <= grant_data ? GRANT_DATA : GRANT_FETCH;
                        pc_q        <= pc_instr_access;
                        daddr_q     <= data_addr;
                        we_q        <= grant_data && data_we;
                        cnt         <= CNT_W'(RAM_LAT - 1);
                        xfer        <= 1'b1;
                        busy        <= 1'b1;
                        sel_add_bus <= grant_data;
                        ram_we      <= grant_data && data_we;
                        ram_wdata   <= (grant_data && data_we) ? data_wdata : '0;
                        state       <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    ram_we    <= 1'b0;
                    ram_wdata <= '0;
                    if (cnt != '0) begin
                        state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    cnt <= cnt - CNT_W'(1);
                end
                ST_RESP: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase

            if (last_beat) begin
                if (grant == GRANT_FETCH) begin
                    instr_out <= ram_rdata;
                end else if (!we_q) begin
                    data_rdata <= ram_rdata;
                end
                instr_valid <= (grant == GRANT_FETCH);
                data_valid  <= (grant == GRANT_DATA);
                sel_add_bus <= 1'b0;
                xfer        <= 1'b0;
                state       <= ST_RESP;
            end
        end
    end

endmodule

// File: tb/tb_memory_access_controller.sv
// Randomized scoreboard bench: instance 0 runs with RAM_LAT=3, instance 1 with RAM_LAT=1.
module tb_memory_access_controller;

    typedef struct {
        bit          is_data;
        int          vcyc;
        logic [31:0] data;
    } sb_t;

    typedef struct {
        bit          busy;
        bit          sel;
        bit          live;
        logic [15:0] addr;
        bit          we;
        logic [31:0] wdata;
    } bx_t;

    logic        clk = 1'b0;
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;

    logic        rst         [2];
    logic        fetch_req   [2];
    logic        data_req    [2];
    logic        data_we     [2];
    logic [7:0]  pc          [2];
    logic [15:0] daddr       [2];
    logic [31:0] wdata       [2];
    logic        sel         [2];
    logic [15:0] addr_bus    [2];
    logic        ram_we      [2];
    logic [31:0] ram_wdata   [2];
    logic [31:0] instr_out   [2];
    logic        instr_valid [2];
    logic [31:0] data_rdata  [2];
    logic        data_valid  [2];
    logic        busy        [2];

    sb_t         sbq [2][$];
    bx_t         bexp [int];
    bit          last_grant [2];
    logic [31:0] last_ldr   [2];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] ramf(input logic [15:0] a);
        return (32'(a) * 32'h9E37_79B1) ^ 32'hC3A5_1E2D;
    endfunction

    function automatic int lat(input int u);
        return (u == 0) ? 3 : 1;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : gen
        logic [15:0] d1, d2;
        logic [31:0] rd;
        // RAM stub: word is a hash of the address presented RAM_LAT-1 cycles earlier
        always @(posedge clk) begin
            d1 <= addr_bus[g];
            d2 <= d1;
        end
        assign rd = ramf(g == 0 ? d2 : addr_bus[g]);

        memory_access_controller #(.RAM_LAT(g == 0 ? 3 : 1)) dut (
            .clk                 (clk),
            .reset               (rst[g]),
            .fetch_req           (fetch_req[g]),
            .pc_instr_access     (pc[g]),
            .data_req            (data_req[g]),
            .data_we             (data_we[g]),
            .data_addr           (daddr[g]),
            .data_wdata          (wdata[g]),
            .ram_rdata           (rd),
            .sel_add_bus         (sel[g]),
            .address_add_bus_out (addr_bus[g]),
            .ram_we              (ram_we[g]),
            .ram_wdata           (ram_wdata[g]),
            .instr_out           (instr_out[g]),
            .instr_valid         (instr_valid[g]),
            .data_rdata          (data_rdata[g]),
            .data_valid          (data_valid[g]),
            .busy                (busy[g])
        );

        initial forever begin
            @(negedge clk);
            #1;
            mon(g);
        end
    end

    task automatic mon(input int u);
        int  key;
        sb_t s;
        bx_t b;
        key = cyc * 2 + u;
        chk("valid_exclusive", 32'(instr_valid[u] && data_valid[u]), 32'd0);
        if (instr_valid[u] || data_valid[u]) begin
            if (sbq[u].size() == 0) begin
                chk("spurious_valid", 32'(cyc), 32'hFFFF_FFFF);
            end else begin
                s = sbq[u].pop_front();
                chk("valid_kind", 32'(data_valid[u]), 32'(s.is_data));
                chk("valid_cycle", 32'(cyc), 32'(s.vcyc));
                if (s.is_data) chk("data_rdata", data_rdata[u], s.data);
                else           chk("instr_out", instr_out[u], s.data);
            end
        end
        if (bexp.exists(key)) begin
            b = bexp[key];
            bexp.delete(key);
        end else begin
            b = '{1'b0, 1'b0, 1'b1, 16'h0, 1'b0, 32'h0};
        end
        chk("busy", 32'(busy[u]), 32'(b.busy));
        chk("sel_add_bus", 32'(sel[u]), 32'(b.sel));
        chk("address", 32'(addr_bus[u]), b.live ? {24'h0, pc[u]} : 32'(b.addr));
        chk("ram_we", 32'(ram_we[u]), 32'(b.we));
        chk("ram_wdata", ram_wdata[u], b.wdata);
    endtask

    // Record expected completion and per-cycle bus behaviour of a transaction granted at cycle t.
    task automatic issue(input int u, input bit is_data, input bit we, input logic [7:0] p,
                         input logic [15:0] da, input logic [31:0] wd, input int t);
        int  l;
        sb_t s;
        bx_t b;
        bit  w;
        l = lat(u);
        s.is_data = is_data;
        s.vcyc    = t + 1 + l;
        if (!is_data) begin
            s.data = ramf({8'h00, p});
        end else if (!we) begin
            s.data = ramf(da);
            last_ldr[u] = s.data;
        end else begin
            s.data = last_ldr[u];
        end
        sbq[u].push_back(s);
        last_grant[u] = is_data;
        b = '{1'b0, 1'b0, 1'b1, 16'h0, 1'b0, 32'h0};
        bexp[t * 2 + u] = b;
        for (int k = 1; k <= l; k++) begin
            w = (k == 1) && is_data && we;
            b = '{1'b1, is_data, 1'b0, is_data ? da : {8'h00, p}, w, w ? wd : 32'h0};
            bexp[(t + k) * 2 + u] = b;
        end
        b = '{1'b1, 1'b0, 1'b1, 16'h0, 1'b0, 32'h0};
        bexp[(t + 1 + l) * 2 + u] = b;
    endtask

    // Must be entered at a falling edge while the DUT is idle.
    task automatic single(input int u, input bit is_data, input bit we, input logic [7:0] p,
                          input logic [15:0] da, input logic [31:0] wd,
                          input bit drop, input bit scr, input bit hold);
        int c, v, l;
        l = lat(u);
        c = cyc;
        pc[u] = p; daddr[u] = da; wdata[u] = wd; data_we[u] = we;
        if (is_data) data_req[u] = 1'b1;
        else         fetch_req[u] = 1'b1;
        issue(u, is_data, we, p, da, wd, c);
        v = c + 1 + l;
        if (hold) begin
            issue(u, is_data, we, p, da, wd, c + 2 + l);
            v = c + 3 + 2 * l;
        end
        @(negedge clk);
        if (drop && !hold) begin
            fetch_req[u] = 1'b0;
            data_req[u]  = 1'b0;
        end
        if (scr && !hold) begin
            pc[u]      = p + 8'd1;
            daddr[u]   = 16'($urandom);
            wdata[u]   = $urandom;
            data_we[u] = 1'($urandom);
        end
        while (cyc < v) @(negedge clk);
        fetch_req[u] = 1'b0;
        data_req[u]  = 1'b0;
    endtask

    task automatic both(input int u, input logic [7:0] p, input logic [15:0] da,
                        input logic [31:0] wd, input bit we, input int np);
        int c, l, lf, ld, t;
        bit d;
        l = lat(u);
        c = cyc;
        lf = c; ld = c;
        pc[u] = p; daddr[u] = da; wdata[u] = wd; data_we[u] = we;
        fetch_req[u] = 1'b1;
        data_req[u]  = 1'b1;
        for (int i = 0; i < 2 * np; i++) begin
            d = !last_grant[u];
            t = c + i * (2 + l);
            issue(u, d, we, p, da, wd, t);
            if (d) ld = t + 1 + l;
            else   lf = t + 1 + l;
        end
        while (cyc < ((lf > ld) ? lf : ld)) begin
            @(negedge clk);
            if (cyc == lf) fetch_req[u] = 1'b0;
            if (cyc == ld) data_req[u]  = 1'b0;
        end
    endtask

    task automatic chk_reset_outputs(input int u);
        chk("rst_busy", 32'(busy[u]), 32'd0);
        chk("rst_sel", 32'(sel[u]), 32'd0);
        chk("rst_address", 32'(addr_bus[u]), {24'h0, pc[u]});
        chk("rst_ram_we", 32'(ram_we[u]), 32'd0);
        chk("rst_ram_wdata", ram_wdata[u], 32'd0);
        chk("rst_instr_out", instr_out[u], 32'd0);
        chk("rst_instr_valid", 32'(instr_valid[u]), 32'd0);
        chk("rst_data_rdata", data_rdata[u], 32'd0);
        chk("rst_data_valid", 32'(data_valid[u]), 32'd0);
    endtask

    // Fetch aborted by reset during WAIT: no pulse may follow.
    task automatic reset_abort(input int u);
        int c;
        logic [7:0] p;
        bx_t b;
        c = cyc;
        p = 8'($urandom);
        pc[u] = p;
        fetch_req[u] = 1'b1;
        b = '{1'b0, 1'b0, 1'b1, 16'h0, 1'b0, 32'h0};
        bexp[c * 2 + u] = b;
        b = '{1'b1, 1'b0, 1'b0, {8'h00, p}, 1'b0, 32'h0};
        bexp[(c + 1) * 2 + u] = b;
        bexp[(c + 2) * 2 + u] = b;
        @(negedge clk);
        @(negedge clk);
        #2;
        rst[u] = 1'b1;
        fetch_req[u] = 1'b0;
        #1;
        chk_reset_outputs(u);
        @(negedge clk);
        rst[u] = 1'b0;
        last_grant[u] = 1'b0;
        last_ldr[u] = 32'h0;
    endtask

    task automatic run_random(input int u, input int n);
        logic [7:0]  p;
        logic [15:0] da;
        logic [31:0] wd;
        bit          we;
        int          scen;
        int          gap;
        for (int i = 0; i < n; i++) begin
            gap = $urandom_range(0, 2);
            repeat (gap) @(negedge clk);
            @(negedge clk);
            p = 8'($urandom); da = 16'($urandom); wd = $urandom; we = 1'($urandom);
            scen = $urandom_range(0, 3);
            case (scen)
                0: single(u, 1'b0, we, p, da, wd, 1'($urandom), 1'($urandom), 1'b0);
                1: single(u, 1'b1, we, p, da, wd, 1'($urandom), 1'($urandom), 1'b0);
                2: both(u, p, da, wd, we, $urandom_range(1, 2));
                default: single(u, 1'($urandom), we, p, da, wd, 1'b0, 1'b0, 1'b1);
            endcase
        end
    endtask

    initial begin
        for (int u = 0; u < 2; u++) begin
            rst[u] = 1'b1; fetch_req[u] = 1'b0; data_req[u] = 1'b0; data_we[u] = 1'b0;
            pc[u] = 8'h5C; daddr[u] = 16'h0; wdata[u] = 32'h0;
            last_grant[u] = 1'b0; last_ldr[u] = 32'h0;
        end
        repeat (3) @(negedge clk);
        #2;
        chk_reset_outputs(0);
        chk_reset_outputs(1);
        @(negedge clk);
        rst[0] = 1'b0;
        rst[1] = 1'b0;

        for (int u = 1; u >= 0; u--) begin
            @(negedge clk); single(u, 1'b0, 1'b0, 8'h2A, 16'h0, 32'h0, 1'b0, 1'b0, 1'b0);
            @(negedge clk); single(u, 1'b1, 1'b0, 8'h00, 16'h1234, 32'h0, 1'b0, 1'b0, 1'b0);
            @(negedge clk); single(u, 1'b1, 1'b1, 8'h00, 16'h00F0, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0);
            @(negedge clk); both(u, 8'h33, 16'hBEEF, 32'h0, 1'b0, 2);
            @(negedge clk); single(u, 1'b0, 1'b0, 8'h10, 16'h0, 32'h0, 1'b0, 1'b1, 1'b0);
            @(negedge clk); single(u, 1'b1, 1'b0, 8'h00, 16'h4321, 32'h0, 1'b1, 1'b0, 1'b0);
            @(negedge clk); single(u, 1'b0, 1'b0, 8'h77, 16'h0, 32'h0, 1'b0, 1'b0, 1'b1);
        end
        @(negedge clk); reset_abort(0);
        @(negedge clk); single(0, 1'b0, 1'b0, 8'h4B, 16'h0, 32'h0, 1'b0, 1'b0, 1'b0);

        run_random(0, 60);
        run_random(1, 40);

        repeat (6) @(negedge clk);
        chk("sb_left_0", 32'(sbq[0].size()), 32'd0);
        chk("sb_left_1", 32'(sbq[1].size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
